// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared state encoding and sizing helper for the truth-table sweeper
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Number of truth-table rows for a function of n_in inputs.
  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_lut_select.sv
// rtl/truth_table_sweeper_lut_select.sv - picks one truth-table bit for the current row
module truth_table_sweeper_lut_select
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int ROWS = rows_of(N_IN)
) (
  input  logic [ROWS-1:0] i_lut,
  input  logic [N_IN-1:0] i_row,
  output logic            o_bit
);

  // Plain ROWS:1 mux; bit i of the table is the function value for row i.
  assign o_bit = i_lut[i_row];

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input rows of N_FUNC LUT functions over a valid/ready stream
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic [N_FUNC*(1<<N_IN)-1:0]   lut_in,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          out_valid,
  output logic [N_IN-1:0]               out_vec,
  output logic [N_FUNC-1:0]             out_f,
  output logic                          done,
  output logic                          equiv,
  output logic [N_IN-1:0]               mismatch_idx,
  output logic [N_FUNC*(N_IN+1)-1:0]    ones_count
);

  localparam int ROWS = rows_of(N_IN);
  localparam int CW   = N_IN + 1;
  // With a single function the comparison partner is itself, so no mismatch can arise.
  localparam int F1   = (N_FUNC > 1) ? 1 : 0;
  localparam logic [N_IN-1:0] LAST_ROW = {N_IN{1'b1}};

  state_e                     r_state;
  state_e                     w_next;
  logic [N_FUNC*ROWS-1:0]     r_lut;
  logic [N_IN-1:0]            r_row;
  logic                       r_mode;
  logic [N_FUNC*CW-1:0]       r_cnt;
  logic                       r_equiv;
  logic [N_IN-1:0]            r_idx;

  logic [N_FUNC-1:0]          w_f;
  logic                       w_load;
  logic                       w_xfer;
  logic                       w_mis;
  logic                       w_last;
  logic                       w_stop;

  genvar g;
  generate
    for (g = 0; g < N_FUNC; g++) begin : g_sel
      truth_table_sweeper_lut_select #(.N_IN(N_IN)) u_sel (
        .i_lut (r_lut[g*ROWS +: ROWS]),
        .i_row (r_row),
        .o_bit (w_f[g])
      );
    end
  endgenerate

  // A start is honoured everywhere except mid-sweep.
  assign w_load = start & (r_state != S_SWEEP);
  assign w_xfer = (r_state == S_SWEEP) & out_ready;
  assign w_mis  = w_f[0] ^ w_f[F1];
  assign w_last = (r_row == LAST_ROW);
  assign w_stop = w_xfer & (w_last | (r_mode & w_mis));

  assign out_vec      = r_row;
  assign out_f        = w_f;
  assign equiv        = r_equiv;
  assign mismatch_idx = r_idx;
  assign ones_count   = r_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SWEEP;
      end
      S_SWEEP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_stop) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_SWEEP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // LUT capture, row advance, minterm counters and first-mismatch tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lut   <= '0;
      r_row   <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_equiv <= 1'b1;
      r_idx   <= '0;
    end else if (w_load) begin
      r_lut   <= lut_in;
      r_row   <= '0;
      r_mode  <= mode;
      r_cnt   <= '0;
      r_equiv <= 1'b1;
      r_idx   <= '0;
    end else if (w_xfer) begin
      for (int k = 0; k < N_FUNC; k++) begin
        r_cnt[k*CW +: CW] <= r_cnt[k*CW +: CW] + CW'(w_f[k]);
      end
      if (w_mis && r_equiv) begin
        r_equiv <= 1'b0;
        r_idx   <= r_row;
      end
      // Row holds on the terminating transfer so it never wraps.
      if (!w_stop) r_row <= r_row + 1'b1;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - table-driven and randomized checks of truth_table_sweeper
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [15:0] lut_in;
  logic        out_ready;
  logic        busy, out_valid, done, equiv;
  logic [2:0]  out_vec, mismatch_idx;
  logic [1:0]  out_f;
  logic [7:0]  ones_count;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] cap_f [8];

  truth_table_sweeper #(.N_IN(3), .N_FUNC(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mode         (mode),
    .lut_in       (lut_in),
    .out_ready    (out_ready),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_vec      (out_vec),
    .out_f        (out_f),
    .done         (done),
    .equiv        (equiv),
    .mismatch_idx (mismatch_idx),
    .ones_count   (ones_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lut;
    bit          m;
    int          stall_row;
    int          stall_len;
    bit          mid_start;
    int          c0, c1;
    bit          eq;
    int          idx;
    int          rows;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the rows in order, stopping after the last row or, in
  // mode 1, after the first row where f0 and f1 disagree.
  function automatic void model(input logic [15:0] lut, input bit m,
                                output int rows, output int c0, output int c1,
                                output bit eq, output int idx);
    rows = 0; c0 = 0; c1 = 0; eq = 1; idx = 0;
    for (int r = 0; r < 8; r++) begin
      rows++;
      c0 += int'(lut[r]);
      c1 += int'(lut[8+r]);
      if (lut[r] != lut[8+r] && eq) begin
        eq  = 0;
        idx = r;
        if (m) break;
      end
    end
  endfunction

  task automatic run_sweep(input logic [15:0] lut, input bit m, input int stall_row,
                           input int stall_len, input bit rnd, input bit mid_start);
    int  e_rows, e_c0, e_c1, e_idx;
    bit  e_eq;
    int  j, cyc, run0, run1, stall_left;
    bit  rdy, stalled_any;
    model(lut, m, e_rows, e_c0, e_c1, e_eq, e_idx);
    @(posedge clk); #1;
    start = 1'b1; lut_in = lut; mode = m; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; lut_in = 16'($urandom);
    j = 0; cyc = 0; run0 = 0; run1 = 0; stall_left = stall_len; stalled_any = 0;
    while (!done) begin
      if (cyc > 200 || j > 7) begin
        chk("sweep_bound", 64'(cyc), 64'(e_rows));
        break;
      end
      chk("valid", 64'(out_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("out_vec", 64'(out_vec), 64'(j));
      chk("out_f", 64'(out_f), 64'({lut[8+j], lut[j]}));
      chk("run_count", 64'(ones_count), 64'({4'(run1), 4'(run0)}));
      cap_f[j] = out_f;
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else if (j == stall_row && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else rdy = 1'b1;
      if (!rdy) stalled_any = 1;
      start = mid_start && (cyc == 2);
      if (start) lut_in = ~lut;
      out_ready = rdy;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (rdy) begin
        run0 += int'(lut[j]);
        run1 += int'(lut[8+j]);
        j++;
      end
    end
    out_ready = 1'b0;
    chk("rows", 64'(j), 64'(e_rows));
    if (!stalled_any) chk("latency", 64'(cyc), 64'(e_rows));
    chk("done", 64'(done), 64'd1);
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    chk("counts", 64'(ones_count), 64'({4'(e_c1), 4'(e_c0)}));
    chk("equiv", 64'(equiv), 64'(e_eq));
    chk("mis_idx", 64'(mismatch_idx), 64'(e_idx));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_equiv"}, 64'(equiv), 64'd1);
    chk({tag, "_idx"}, 64'(mismatch_idx), 64'd0);
    chk({tag, "_cnt"}, 64'(ones_count), 64'd0);
    chk({tag, "_vec"}, 64'(out_vec), 64'd0);
    chk({tag, "_f"}, 64'(out_f), 64'd0);
  endtask

  initial begin
    vec_t tbl[5];
    logic [1:0] golden_f [8];
    int tmo;
    tbl[0] = '{16'hF0CD, 0, -1, 0, 0, 5, 4, 0, 0, 8};
    tbl[1] = '{16'hF0CD, 1, -1, 0, 0, 1, 0, 0, 0, 1};
    tbl[2] = '{16'hCDCD, 1, -1, 0, 0, 5, 5, 1, 0, 8};
    tbl[3] = '{16'hF0CD, 0,  4, 3, 0, 5, 4, 0, 0, 8};
    tbl[4] = '{16'h00FF, 0, -1, 0, 1, 8, 0, 0, 0, 8};
    golden_f[0] = 2'b01; golden_f[1] = 2'b00; golden_f[2] = 2'b01; golden_f[3] = 2'b01;
    golden_f[4] = 2'b10; golden_f[5] = 2'b10; golden_f[6] = 2'b11; golden_f[7] = 2'b11;

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; lut_in = 16'hA5A5; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    reset_n = 1'b1;

    // Spec vectors; entry 4 restarts straight from DONE of entry 3.
    for (int t = 0; t < 5; t++) begin
      run_sweep(tbl[t].lut, tbl[t].m, tbl[t].stall_row, tbl[t].stall_len, 1'b0, tbl[t].mid_start);
      chk($sformatf("tbl%0d_cnt", t), 64'(ones_count), 64'({4'(tbl[t].c1), 4'(tbl[t].c0)}));
      chk($sformatf("tbl%0d_eq", t), 64'(equiv), 64'(tbl[t].eq));
      chk($sformatf("tbl%0d_idx", t), 64'(mismatch_idx), 64'(tbl[t].idx));
      if (t == 0 || t == 3)
        for (int r = 0; r < 8; r++)
          chk($sformatf("tbl%0d_fseq%0d", t, r), 64'(cap_f[r]), 64'(golden_f[r]));
    end

    // DONE holds until a new start.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_cnt", 64'(ones_count), 64'h08);

    // Reset in the middle of a sweep abandons it.
    start = 1'b1; lut_in = 16'hF0CD; mode = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tmo = 0;
    while (out_vec != 3'd5 && tmo < 20) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("reach_row5", 64'(out_vec), 64'd5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_idle("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done), 64'd0);
    chk("midrst_no_busy", 64'(busy), 64'd0);
    run_sweep(16'hF0CD, 1'b0, -1, 0, 1'b0, 1'b0);

    // Random LUTs, modes and backpressure against the reference model.
    for (int i = 0; i < 24; i++)
      run_sweep(16'($urandom), 1'($urandom), -1, 0, 1'b1, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
